// File: rtl/pp_tree_acc_pkg.sv
// ---------------------------------------------------------------------------
// pp_tree_pkg
// Shared constants and helpers for the partial-product adder tree with
// accumulator (pp_tree_acc) and its per-level sub-module (pp_tree_level).
//   - DEF_* : default parameter values for the tree and accumulator
//   - calc_sw  : width of the final weighted sum
//   - calc_lvl : number of tree levels (log2 of the partial-product count)
//   - calc_iw  : input node width of a given tree level
//   - side_t   : valid/sideband bundle carried alongside the data
// ---------------------------------------------------------------------------
package pp_tree_pkg;

  localparam int DEF_NPP   = 32'sd8;
  localparam int DEF_PPW   = 32'sd18;
  localparam int DEF_SHIFT = 32'sd2;
  localparam int DEF_ACCW  = 32'sd48;

  // Valid bit plus accumulate sideband, pipelined with each sample.
  typedef struct packed {
    logic valid;
    logic en;
    logic clr;
  } side_t;

  // Width of the weighted sum: top partial product sits SHIFT*(NPP-1) up.
  function automatic int calc_sw(input int ppw, input int shift, input int npp);
    return ppw + shift * (npp - 32'sd1);
  endfunction

  // ceil(log2(npp)); npp is a power of two so this is exact.
  function automatic int calc_lvl(input int npp);
    int lvl;
    lvl = 32'sd0;
    for (int i = 0; i < 30; i++) begin
      if ((32'sd1 <<< i) < npp) begin
        lvl = lvl + 32'sd1;
      end
    end
    return lvl;
  endfunction

  // Node width entering level k: each earlier level added SHIFT*2^j bits.
  function automatic int calc_iw(input int ppw, input int shift, input int k);
    return ppw + shift * ((32'sd1 <<< k) - 32'sd1);
  endfunction

endpackage

// File: rtl/pp_tree_acc_level.sv
// ---------------------------------------------------------------------------
// pp_tree_level
// One registered level of the pairwise adder tree. Node j of the output is
//   sext(din[2j]) + (sext(din[2j+1]) << STEP)
// computed in IW+STEP bits. Data registers load only on a valid sample so
// the last level holds its value between samples.
// Parameters: NODES (input node count, even), IW (input node width),
//             STEP (left shift applied to the odd node).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_en/in_clr  valid and accumulate sideband of the input sample
//   din                    NODES packed signed nodes, node i at [i*IW +: IW]
//   out_valid/out_en/out_clr  registered sideband (en/clr masked by valid)
//   dout                   NODES/2 packed signed nodes of width IW+STEP
// ---------------------------------------------------------------------------
module pp_tree_level
  import pp_tree_pkg::*;
#(
  parameter int NODES = 32'sd8,
  parameter int IW    = 32'sd18,
  parameter int STEP  = 32'sd2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 in_en,
  input  logic                                 in_clr,
  input  logic [NODES*IW-1:0]                  din,
  output logic                                 out_valid,
  output logic                                 out_en,
  output logic                                 out_clr,
  output logic [(NODES/32'sd2)*(IW+STEP)-1:0]  dout
);

  localparam int OW = IW + STEP;
  localparam int NO = NODES / 32'sd2;

  logic [NO*OW-1:0] node_s;
  logic [NO*OW-1:0] dout_r;
  side_t            side_r;

  // Pairwise signed add; odd node carries the higher weight.
  always_comb begin
    node_s = '0;
    for (int j = 0; j < NO; j++) begin
      node_s[j*OW +: OW] = OW'($signed(din[(2*j)*IW +: IW]))
                         + (OW'($signed(din[(2*j+1)*IW +: IW])) <<< STEP);
    end
  end

  // Level register: sideband every cycle, data only on a valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      side_r <= '0;
      dout_r <= '0;
    end else begin
      side_r <= {in_valid, in_valid & in_en, in_valid & in_clr};
      if (in_valid) begin
        dout_r <= node_s;
      end
    end
  end

  assign out_valid = side_r.valid;
  assign out_en    = side_r.en;
  assign out_clr   = side_r.clr;
  assign dout      = dout_r;

endmodule

// File: rtl/pp_tree_acc.sv
// ---------------------------------------------------------------------------
// pp_tree_acc
// Pipelined weighted sum of NPP signed partial products followed by a
// signed running accumulator.
//   sum = sum_i pp[i] * 2^(SHIFT*i), one register per tree level
//   (latency LVL cycles, one sample per cycle). The accumulator updates one
//   cycle after out_valid under control of the pipelined acc_en/acc_clr.
// Optional feature macro: PP_TREE_ACC_SAT_EN -- when defined the accumulator
//   clamps to the signed extreme on overflow; otherwise it wraps.
// Parameters: NPP (power of two, 2..16), PPW, SHIFT, ACCW (>= SW).
// Ports:
//   clk        clock (rising edge)
//   rst        synchronous active-high reset
//   in_valid   pp holds a valid sample set
//   pp         NPP packed signed partial products, pp[i] at [i*PPW +: PPW]
//   acc_en     add this sample's sum into the accumulator
//   acc_clr    restart the accumulator from this sample (sum or 0)
//   out_valid  sum valid this cycle
//   sum        signed weighted sum, SW bits, held while out_valid=0
//   acc_valid  acc updated this cycle
//   acc        signed running accumulator, ACCW bits
//   ovf        sticky accumulator overflow flag
// ---------------------------------------------------------------------------
module pp_tree_acc
  import pp_tree_pkg::*;
#(
  parameter  int NPP   = DEF_NPP,
  parameter  int PPW   = DEF_PPW,
  parameter  int SHIFT = DEF_SHIFT,
  parameter  int ACCW  = DEF_ACCW,
  localparam int SW    = calc_sw(PPW, SHIFT, NPP),
  localparam int LVL   = calc_lvl(NPP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NPP*PPW-1:0] pp,
  input  logic              acc_en,
  input  logic              acc_clr,
  output logic              out_valid,
  output logic [SW-1:0]     sum,
  output logic              acc_valid,
  output logic [ACCW-1:0]   acc,
  output logic              ovf
);

  // Elaboration-time parameter sanity.
  if ((NPP < 32'sd2) || (NPP > 32'sd16) || ((NPP & (NPP - 32'sd1)) != 32'sd0)) begin : g_bad_npp
    $error("pp_tree_acc: NPP must be a power of two in 2..16");
  end
  if (ACCW < SW) begin : g_bad_accw
    $error("pp_tree_acc: ACCW must be at least SW");
  end

  // ------------------------------------------------------------------------
  // Adder tree: level k halves the node count and widens by SHIFT*2^k.
  // ------------------------------------------------------------------------
  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int NODES = NPP >>> k;
    localparam int IW    = calc_iw(PPW, SHIFT, k);
    localparam int STEP  = SHIFT <<< k;
    localparam int OW    = IW + STEP;

    logic [NODES*IW-1:0]           din_s;
    logic                          vin_s;
    logic                          ein_s;
    logic                          cin_s;
    logic [(NODES/32'sd2)*OW-1:0]  dout_s;
    logic                          vout_s;
    logic                          eout_s;
    logic                          cout_s;

    if (k == 0) begin : g_src
      assign din_s = pp;
      assign vin_s = in_valid;
      assign ein_s = acc_en;
      assign cin_s = acc_clr;
    end else begin : g_chain
      assign din_s = g_lvl[k-1].dout_s;
      assign vin_s = g_lvl[k-1].vout_s;
      assign ein_s = g_lvl[k-1].eout_s;
      assign cin_s = g_lvl[k-1].cout_s;
    end

    pp_tree_level #(
      .NODES (NODES),
      .IW    (IW),
      .STEP  (STEP)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vin_s),
      .in_en     (ein_s),
      .in_clr    (cin_s),
      .din       (din_s),
      .out_valid (vout_s),
      .out_en    (eout_s),
      .out_clr   (cout_s),
      .dout      (dout_s)
    );
  end

  logic          sum_valid_s;
  logic          sum_en_s;
  logic          sum_clr_s;
  logic [SW-1:0] sum_s;

  assign sum_valid_s = g_lvl[LVL-1].vout_s;
  assign sum_en_s    = g_lvl[LVL-1].eout_s;
  assign sum_clr_s   = g_lvl[LVL-1].cout_s;
  assign sum_s       = g_lvl[LVL-1].dout_s;

  // ------------------------------------------------------------------------
  // Accumulator stage
  // ------------------------------------------------------------------------
  logic signed [ACCW-1:0] acc_r;
  logic                   ovf_r;
  logic                   acc_valid_r;
  logic signed [ACCW-1:0] sum_ext_s;
  logic signed [ACCW-1:0] add_s;
  logic signed [ACCW-1:0] acc_add_s;
  logic                   add_ovf_s;

  // Signed add with overflow detect; overflow only when both operands
  // share a sign and the result sign differs.
  always_comb begin
    sum_ext_s = ACCW'($signed(sum_s));
    add_s     = acc_r + sum_ext_s;
    add_ovf_s = (acc_r[ACCW-1] == sum_ext_s[ACCW-1]) &&
                (add_s[ACCW-1] != acc_r[ACCW-1]);
`ifdef PP_TREE_ACC_SAT_EN
    if (add_ovf_s) begin
      if (acc_r[ACCW-1]) begin
        acc_add_s = {1'b1, {(ACCW-1){1'b0}}};
      end else begin
        acc_add_s = {1'b0, {(ACCW-1){1'b1}}};
      end
    end else begin
      acc_add_s = add_s;
    end
`else
    acc_add_s = add_s;
`endif
  end

  // Accumulator update one cycle after the sum leaves the tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      acc_valid_r <= 1'b0;
    end else begin
      acc_valid_r <= sum_valid_s & (sum_en_s | sum_clr_s);
      if (sum_valid_s) begin
        case ({sum_clr_s, sum_en_s})
          2'b11: begin
            acc_r <= sum_ext_s;
            ovf_r <= 1'b0;
          end
          2'b10: begin
            acc_r <= '0;
            ovf_r <= 1'b0;
          end
          2'b01: begin
            acc_r <= acc_add_s;
            ovf_r <= ovf_r | add_ovf_s;
          end
          default: begin
            acc_r <= acc_r;
            ovf_r <= ovf_r;
          end
        endcase
      end
    end
  end

  assign out_valid = sum_valid_s;
  assign sum       = sum_s;
  assign acc_valid = acc_valid_r;
  assign acc       = acc_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pp_tree_acc.sv
// ---------------------------------------------------------------------------
// tb_pp_tree_acc
// Directed, table-driven bench for pp_tree_acc. Two instances share the
// stimulus: u_dut at default parameters (ACCW=48) and u_dut32 with ACCW=32
// for the overflow sequence. Inputs change #1 after a rising edge; outputs
// are sampled at the same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_pp_tree_acc;

  localparam int NPP = 8;
  localparam int PPW = 18;
  localparam int SW  = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [NPP*PPW-1:0] pp;
  logic               acc_en;
  logic               acc_clr;

  logic               out_valid;
  logic [SW-1:0]      sum;
  logic               acc_valid;
  logic [47:0]        acc;
  logic               ovf;

  logic               out_valid32;
  logic [SW-1:0]      sum32;
  logic               acc_valid32;
  logic [31:0]        acc32;
  logic               ovf32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pp_tree_acc u_dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .pp (pp),
    .acc_en (acc_en), .acc_clr (acc_clr),
    .out_valid (out_valid), .sum (sum), .acc_valid (acc_valid),
    .acc (acc), .ovf (ovf)
  );

  pp_tree_acc #(.ACCW(32)) u_dut32 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .pp (pp),
    .acc_en (acc_en), .acc_clr (acc_clr),
    .out_valid (out_valid32), .sum (sum32), .acc_valid (acc_valid32),
    .acc (acc32), .ovf (ovf32)
  );

  typedef struct {
    logic [PPW-1:0] p [NPP];
    logic [SW-1:0]  exp_sum;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single sample with only pp[idx]=val; other pp are zero.
  function automatic logic [NPP*PPW-1:0] one_pp(input int idx, input logic [PPW-1:0] val);
    logic [NPP*PPW-1:0] r;
    r = '0;
    r[idx*PPW +: PPW] = val;
    return r;
  endfunction

  logic [31:0] exp_acc32 [4];
  logic [47:0] exp_acc48 [4];
  logic        exp_ovf32 [4];
  logic [31:0] exp_acc_s;

  initial begin
    // ---------------- vector table ----------------
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NPP; i++) vecs[v].p[i] = '0;
    end
    for (int i = 0; i < NPP; i++) vecs[0].p[i] = 18'd1;
    vecs[0].exp_sum = 32'h0000_5555;
    vecs[1].p[0] = 18'h3FFFF;               vecs[1].exp_sum = 32'hFFFF_FFFF;
    vecs[2].p[7] = 18'h1FFFF;               vecs[2].exp_sum = 32'h7FFF_C000;
    vecs[3].exp_sum = 32'h0000_0000;
    vecs[4].p[1] = 18'd3; vecs[4].p[2] = 18'h3FFFF; vecs[4].exp_sum = 32'hFFFF_FFFC;
    vecs[5].p[7] = 18'h20000;               vecs[5].exp_sum = 32'h8000_0000;
    vecs[6].p[0] = 18'd7; vecs[6].p[3] = 18'd5; vecs[6].exp_sum = 32'h0000_0147;
    for (int i = 0; i < NPP; i++) vecs[7].p[i] = 18'h3FFFF;
    vecs[7].exp_sum = 32'hFFFF_AAAB;

    // Overflow sequence expectations (ACCW=32), samples all pp[7]=0x1FFFF.
    exp_acc32[0] = 32'h7FFF_C000;
`ifdef PP_TREE_ACC_SAT_EN
    exp_acc32[1] = 32'h7FFF_FFFF;
    exp_acc32[2] = 32'h7FFF_FFFF;
`else
    exp_acc32[1] = 32'hFFFF_8000;
    exp_acc32[2] = 32'h7FFF_4000;
`endif
    exp_acc32[3] = 32'h0000_0000;
    exp_ovf32[0] = 1'b0; exp_ovf32[1] = 1'b1; exp_ovf32[2] = 1'b1; exp_ovf32[3] = 1'b0;
    exp_acc48[0] = 48'h0000_7FFF_C000;
    exp_acc48[1] = 48'h0000_FFFF_8000;
    exp_acc48[2] = 48'h0001_7FFF_4000;
    exp_acc48[3] = 48'h0000_0000_0000;

    // ---------------- reset state ----------------
    rst = 1'b1; in_valid = 1'b0; pp = '0; acc_en = 1'b0; acc_clr = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_acc_valid", 64'(acc_valid), 64'd0);
    chk("rst_acc",       64'(acc),       64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    rst = 1'b0;
    tick();

    // ---------------- table vectors: latency, value, hold ----------------
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NPP; i++) pp[i*PPW +: PPW] = vecs[v].p[i];
      in_valid = 1'b1; acc_en = 1'b0; acc_clr = 1'b0;
      tick();                       // edge 0 captures the sample
      in_valid = 1'b0;
      pp = '1;                      // junk while idle must not reach sum
      chk($sformatf("vec%0d_lat0", v), 64'(out_valid), 64'd0);
      tick();
      chk($sformatf("vec%0d_lat1", v), 64'(out_valid), 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_sum", v),   64'(sum),       64'(vecs[v].exp_sum));
      tick();
      chk($sformatf("vec%0d_vdrop", v), 64'(out_valid), 64'd0);
      chk($sformatf("vec%0d_hold", v),  64'(sum),       64'(vecs[v].exp_sum));
      chk($sformatf("vec%0d_noacc", v), 64'(acc_valid), 64'd0);
    end
    chk("table_acc_untouched", 64'(acc), 64'd0);

    // ---------------- back-to-back accumulate stream ----------------
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin
        pp = one_pp(0, 18'(10 * (c + 1)));
        in_valid = 1'b1; acc_en = 1'b1; acc_clr = (c == 0);
      end else begin
        pp = '0; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
      end
      tick();
      chk($sformatf("stream_ov_c%0d", c), 64'(out_valid), 64'((c >= 2) && (c <= 5)));
      if ((c >= 2) && (c <= 5)) begin
        chk($sformatf("stream_sum_c%0d", c), 64'(sum), 64'(10 * (c - 1)));
      end
      chk($sformatf("stream_av_c%0d", c), 64'(acc_valid), 64'((c >= 3) && (c <= 6)));
      case (c)
        3:       exp_acc_s = 32'd10;
        4:       exp_acc_s = 32'd30;
        5:       exp_acc_s = 32'd60;
        0, 1, 2: exp_acc_s = 32'd0;
        default: exp_acc_s = 32'd100;
      endcase
      chk($sformatf("stream_acc_c%0d", c), 64'(acc), 64'(exp_acc_s));
    end

    // ---------------- sideband without valid / valid without sideband ----------------
    pp = '1; in_valid = 1'b0; acc_en = 1'b1; acc_clr = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("novalid_av_c%0d", c), 64'(acc_valid), 64'd0);
      chk($sformatf("novalid_acc_c%0d", c), 64'(acc), 64'd100);
    end
    pp = one_pp(0, 18'd7); in_valid = 1'b1; acc_en = 1'b0; acc_clr = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      tick();
      chk($sformatf("noen_av_c%0d", c), 64'(acc_valid), 64'd0);
    end
    chk("noen_acc", 64'(acc), 64'd100);
    chk("noen_sum", 64'(sum), 64'd7);

    // ---------------- reset with samples in flight ----------------
    pp = one_pp(7, 18'h1FFFF); in_valid = 1'b1; acc_en = 1'b1; acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    tick();
    rst = 1'b1;                      // sample presented during reset too
    tick();
    rst = 1'b0; in_valid = 1'b0; acc_en = 1'b0; pp = '0;
    chk("mrst_acc_now", 64'(acc), 64'd0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("mrst_ov_c%0d", c),  64'(out_valid),  64'd0);
      chk($sformatf("mrst_av_c%0d", c),  64'(acc_valid),  64'd0);
      chk($sformatf("mrst_av32_c%0d", c), 64'(acc_valid32), 64'd0);
      tick();
    end
    chk("mrst_acc",   64'(acc),   64'd0);
    chk("mrst_acc32", 64'(acc32), 64'd0);
    chk("mrst_ovf32", 64'(ovf32), 64'd0);
    chk("mrst_sum",   64'(sum),   64'd0);

    // ---------------- overflow sequence (ACCW=32 and 48) ----------------
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        pp = one_pp(7, 18'h1FFFF); in_valid = 1'b1;
        acc_en  = (c != 3);
        acc_clr = (c == 0) || (c == 3);
      end else begin
        pp = '0; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
      end
      tick();
      if (c >= 3) begin
        chk($sformatf("ovf_av32_c%0d", c), 64'(acc_valid32), 64'd1);
        chk($sformatf("ovf_acc32_c%0d", c), 64'(acc32), 64'(exp_acc32[c-3]));
        chk($sformatf("ovf_flag32_c%0d", c), 64'(ovf32), 64'(exp_ovf32[c-3]));
        chk($sformatf("ovf_acc48_c%0d", c), 64'(acc), 64'(exp_acc48[c-3]));
        chk($sformatf("ovf_flag48_c%0d", c), 64'(ovf), 64'd0);
      end
    end
    tick();
    chk("ovf_done_av32", 64'(acc_valid32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_tree_acc.md
PP_TREE_ACC -- requirements
Module: pp_tree_acc

Interface
REQ-001 Parameter NPP, default 8: number of partial products; power of two, 2..16.
REQ-002 Parameter PPW, default 18: width of each signed partial product.
REQ-003 Parameter SHIFT, default 2: weight step; partial product i is weighted by 2^(SHIFT*i).
REQ-004 Parameter ACCW, default 48: accumulator width; must be at least SW.
REQ-005 Derived SW = PPW + SHIFT*(NPP-1); LVL = log2(NPP).
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  pp bus holds a valid sample set this cycle.
REQ-009 pp  input  NPP*PPW  packed signed partial products; pp[i] occupies bits [i*PPW +: PPW].
REQ-010 acc_en  input  1  sideband: add this sample's sum into the accumulator.
REQ-011 acc_clr  input  1  sideband: the accumulator restarts from this sample's sum (or from 0 if acc_en=0).
REQ-012 out_valid  output  1  sum is valid this cycle.
REQ-013 sum  output  SW  signed weighted sum of the sample set.
REQ-014 acc_valid  output  1  acc was updated this cycle.
REQ-015 acc  output  ACCW  signed running accumulator.
REQ-016 ovf  output  1  sticky accumulator overflow flag.

Function
REQ-017 sum = sign-extended sum over i of pp[i]*2^(SHIFT*i), exact in SW bits (no overflow possible).
REQ-018 Pairwise adder tree: level k adds node 2j (sign-extended) to node 2j+1 shifted left by SHIFT*2^k; the width grows by SHIFT*2^k per level.
REQ-019 One register stage per tree level; latency in_valid -> out_valid = LVL cycles (3 at default); full throughput, one sample per cycle, no stall.
REQ-020 in_valid, acc_en and acc_clr are pipelined alongside the data; stages holding in_valid=0 carry no effect on acc.
REQ-021 Accumulator updates one cycle after out_valid: acc_clr=1 -> acc = acc_en ? sum : 0; else if acc_en=1 -> acc = acc + sum; else acc is held. acc_valid asserts on that cycle iff (acc_en|acc_clr).
REQ-022 Signed overflow of acc+sum: wraps modulo 2^ACCW and sets ovf (without the saturation option).
REQ-023 ovf clears only on rst or on a valid acc_clr sample; if the cleared-and-loaded value itself overflows (impossible since ACCW>=SW), ovf stays clear.
REQ-024 Back-to-back valid samples with acc_en accumulate every sample; no sample is dropped or double-counted.
REQ-025 sum holds its last value while out_valid=0.

Reset
REQ-026 On rst: all pipeline valid bits = 0, out_valid = 0, acc_valid = 0, sum = 0, acc = 0, ovf = 0.
REQ-027 Reset mid-stream discards all in-flight samples; the first output after reset comes from a sample presented with in_valid=1 at or after the first cycle with rst=0.

Configuration
REQ-028 Macro PP_TREE_ACC_SAT_EN defined: on overflow, acc clamps to 2^(ACCW-1)-1 (positive) or -2^(ACCW-1) (negative), and ovf is set.
REQ-029 PP_TREE_ACC_SAT_EN undefined: acc wraps (REQ-022); no clamp logic is present.

Structure
REQ-030 Shared package pp_tree_pkg holds default parameter constants and the SW/LVL width functions.
REQ-031 One sub-module pp_tree_level: a single registered level (NODES inputs -> NODES/2 outputs, SHIFT step, valid/sideband pass-through), instantiated LVL times via generate.

Verification (default parameters)
REQ-032 All pp[i]=1, in_valid=1 for one cycle -> out_valid three cycles later, sum=21845 (0x5555).
REQ-033 pp[0]=0x3FFFF (-1), others 0 -> sum=0xFFFFFFFF; pp[7]=0x1FFFF, others 0 -> sum=0x7FFFC000.
REQ-034 Stream 4 consecutive samples with sum 10,20,30,40, the first with acc_clr=1 and all with acc_en=1 -> acc=10,30,60,100 on 4 consecutive acc_valid cycles.
REQ-035 ACCW=32, repeated pp[7]=0x1FFFF samples with acc_en=1 -> the second add sets ovf; acc=0x7FFFFFFF with PP_TREE_ACC_SAT_EN, wrapped value without it; a later acc_clr sample clears ovf.
REQ-036 Assert rst while 2 samples are in flight -> no out_valid/acc_valid for them; acc=0, ovf=0.
